// File: rtl/image_transfer_receiver_pkg.sv
// Shared types for the tIImageTransfer destination: macroblock type, FSM
// states and the sticky receive-status word.
package P_ImageProcessing;

   typedef enum logic [1:0] {
      MB_INTRA    = 2'd0,
      MB_INTER    = 2'd1,
      MB_SKIP     = 2'd2,
      MB_RESERVED = 2'd3
   } teMacroBlockType;

   localparam int unsigned LP_MB_PIXELS = 64;
   localparam int unsigned LP_PIX_W     = 24;

   typedef struct packed {
      logic overflow;
      logic length;
      logic type_mismatch;
   } tsRxStatus;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FILL = 2'd1,
      W_DROP = 2'd2
   } teRxWrState;

   typedef enum logic {
      R_IDLE   = 1'b0,
      R_STREAM = 1'b1
   } teRxRdState;

endpackage

// File: rtl/image_transfer_receiver_bank_ram.sv
// Two-bank simple-dual-port pixel buffer; the bank is the address MSB.
// Read data is registered and holds while i_re is low.
module image_transfer_bank_ram
   import P_ImageProcessing::*;
#(
   parameter int unsigned MB_PIXELS = LP_MB_PIXELS,
   parameter int unsigned ADDR_W    = $clog2(MB_PIXELS)
) (
   input  logic                i_clk,
   input  logic                i_we,
   input  logic [ADDR_W:0]     i_waddr,
   input  logic [LP_PIX_W-1:0] i_wdata,
   input  logic                i_re,
   input  logic [ADDR_W:0]     i_raddr,
   output logic [LP_PIX_W-1:0] o_rdata
);

   logic [LP_PIX_W-1:0] r_mem [2*MB_PIXELS];
   logic [LP_PIX_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/image_transfer_receiver.sv
// tIImageTransfer destination: captures macroblocks into a ping-pong buffer,
// checks framing, and replays completed macroblocks over valid/ready.
module image_transfer_receiver
   import P_ImageProcessing::*;
#(
   parameter int unsigned MB_PIXELS = LP_MB_PIXELS,
   parameter int unsigned ADDR_W    = $clog2(MB_PIXELS)
) (
   input  logic            ul1Clock,
   input  logic            ul1ResetN,
   input  logic            ul1Active,
   input  teMacroBlockType eMacroBlockType,
   input  logic [23:0]     ul24Rgb24Data,
   input  logic            ul1MacroBlockEnd,
   output logic            ul1OutValid,
   input  logic            ul1OutReady,
   output logic [23:0]     ul24OutData,
   output teMacroBlockType eOutType,
   output logic            ul1OutLast,
   input  logic            ul1ClearErrors,
   output logic            ul1Overflow,
   output logic            ul1LengthError,
   output logic            ul1TypeError
);

   localparam logic [ADDR_W:0] LP_CNT_MB   = (ADDR_W+1)'(MB_PIXELS);
   localparam logic [ADDR_W:0] LP_CNT_LAST = (ADDR_W+1)'(MB_PIXELS - 1);

   // write side
   teRxWrState      r_wstate, w_wstate_nxt;
   logic [ADDR_W:0] r_wcnt, w_wcnt_nxt;
   logic            r_wbank, w_wbank_nxt;
   teMacroBlockType r_wtype, w_wtype_nxt;
   logic            w_we, w_commit, w_set_ovf, w_set_len, w_set_type;
   logic [ADDR_W:0] w_waddr;
   logic            w_have_free, w_free_bank;

   // bank bookkeeping
   logic [1:0]      r_full, r_issued;
   teMacroBlockType r_btype [2];
   logic            r_oldest;

   // read side
   teRxRdState      r_rstate, w_rstate_nxt;
   logic            r_ibank, w_ibank_nxt;
   logic [ADDR_W-1:0] r_iaddr, w_iaddr_nxt;
   logic            w_re, w_start, w_issue_last;
   logic [ADDR_W:0] w_raddr;
   logic            w_cand_old, w_cand_oth, w_cand_vld, w_cand_bank;
   logic            r_q_vld, r_q_last, r_q_bank;
   logic            r_out_vld, r_out_last, r_out_bank;
   logic [23:0]     r_out_data, w_ram_q;
   teMacroBlockType r_out_type;
   logic            w_load_out, w_q_free, w_out_hs, w_free_rd;

   tsRxStatus       r_status;

   assign w_have_free = ~&r_full;
   assign w_free_bank = r_full[0];

   always_comb begin
      w_wstate_nxt = r_wstate;
      w_wcnt_nxt   = r_wcnt;
      w_wbank_nxt  = r_wbank;
      w_wtype_nxt  = r_wtype;
      w_we         = 1'b0;
      w_waddr      = {r_wbank, r_wcnt[ADDR_W-1:0]};
      w_commit     = 1'b0;
      w_set_ovf    = 1'b0;
      w_set_len    = 1'b0;
      w_set_type   = 1'b0;
      unique case (r_wstate)
         W_IDLE: if (ul1Active) begin
            if (w_have_free) begin
               w_we        = 1'b1;
               w_waddr     = {w_free_bank, ADDR_W'(0)};
               w_wbank_nxt = w_free_bank;
               w_wtype_nxt = eMacroBlockType;
               w_wcnt_nxt  = (ADDR_W+1)'(1);
               if (ul1MacroBlockEnd) w_set_len    = 1'b1;
               else                  w_wstate_nxt = W_FILL;
            end else begin
               w_set_ovf = 1'b1;
               if (!ul1MacroBlockEnd) w_wstate_nxt = W_DROP;
            end
         end
         W_FILL: if (ul1Active) begin
            if (r_wcnt == LP_CNT_MB) begin
               w_set_len    = 1'b1;
               w_wstate_nxt = ul1MacroBlockEnd ? W_IDLE : W_DROP;
            end else begin
               w_we       = 1'b1;
               w_wcnt_nxt = r_wcnt + 1'b1;
               if (eMacroBlockType != r_wtype) w_set_type = 1'b1;
               if (ul1MacroBlockEnd) begin
                  w_wstate_nxt = W_IDLE;
                  if (r_wcnt == LP_CNT_LAST) w_commit  = 1'b1;
                  else                       w_set_len = 1'b1;
               end
            end
         end
         W_DROP: if (ul1Active && ul1MacroBlockEnd) w_wstate_nxt = W_IDLE;
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge ul1Clock or negedge ul1ResetN) begin
      if (!ul1ResetN) begin
         r_wstate <= W_IDLE;
         r_wcnt   <= '0;
         r_wbank  <= 1'b0;
         r_wtype  <= MB_INTRA;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_wcnt   <= w_wcnt_nxt;
         r_wbank  <= w_wbank_nxt;
         r_wtype  <= w_wtype_nxt;
      end
   end

   // Candidate for replay: oldest committed bank, else the other one if the
   // oldest is already being drained through the output pipeline.
   assign w_cand_old  = r_full[r_oldest] & ~r_issued[r_oldest];
   assign w_cand_oth  = r_full[~r_oldest] & ~r_issued[~r_oldest];
   assign w_cand_vld  = w_cand_old | w_cand_oth;
   assign w_cand_bank = w_cand_old ? r_oldest : ~r_oldest;

   assign w_out_hs   = r_out_vld & ul1OutReady;
   assign w_free_rd  = w_out_hs & r_out_last;
   assign w_load_out = r_q_vld & (~r_out_vld | ul1OutReady);
   assign w_q_free   = ~r_q_vld | w_load_out;

   always_comb begin
      w_rstate_nxt = r_rstate;
      w_ibank_nxt  = r_ibank;
      w_iaddr_nxt  = r_iaddr;
      w_raddr      = {r_ibank, r_iaddr};
      w_re         = 1'b0;
      w_start      = 1'b0;
      w_issue_last = 1'b0;
      unique case (r_rstate)
         R_IDLE: if (w_cand_vld && w_q_free) begin
            w_re         = 1'b1;
            w_start      = 1'b1;
            w_raddr      = {w_cand_bank, ADDR_W'(0)};
            w_ibank_nxt  = w_cand_bank;
            w_iaddr_nxt  = ADDR_W'(1);
            w_rstate_nxt = R_STREAM;
         end
         R_STREAM: if (w_q_free) begin
            w_re        = 1'b1;
            w_iaddr_nxt = r_iaddr + 1'b1;
            if (r_iaddr == '1) begin
               w_issue_last = 1'b1;
               w_rstate_nxt = R_IDLE;
            end
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge ul1Clock or negedge ul1ResetN) begin
      if (!ul1ResetN) begin
         r_rstate   <= R_IDLE;
         r_ibank    <= 1'b0;
         r_iaddr    <= '0;
         r_q_vld    <= 1'b0;
         r_q_last   <= 1'b0;
         r_q_bank   <= 1'b0;
         r_out_vld  <= 1'b0;
         r_out_last <= 1'b0;
         r_out_bank <= 1'b0;
         r_out_data <= '0;
         r_out_type <= MB_INTRA;
      end else begin
         r_rstate <= w_rstate_nxt;
         r_ibank  <= w_ibank_nxt;
         r_iaddr  <= w_iaddr_nxt;
         if (w_re) begin
            r_q_vld  <= 1'b1;
            r_q_last <= w_issue_last;
            r_q_bank <= w_raddr[ADDR_W];
         end else if (w_load_out) begin
            r_q_vld <= 1'b0;
         end
         if (w_load_out) begin
            r_out_vld  <= 1'b1;
            r_out_data <= w_ram_q;
            r_out_last <= r_q_last;
            r_out_bank <= r_q_bank;
            r_out_type <= r_btype[r_q_bank];
         end else if (w_out_hs) begin
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
         end
      end
   end

   // A commit and a free in the same cycle always target different banks.
   always_ff @(posedge ul1Clock or negedge ul1ResetN) begin
      if (!ul1ResetN) begin
         r_full     <= '0;
         r_issued   <= '0;
         r_oldest   <= 1'b0;
         r_btype[0] <= MB_INTRA;
         r_btype[1] <= MB_INTRA;
      end else begin
         if (w_commit) begin
            r_full[r_wbank]  <= 1'b1;
            r_btype[r_wbank] <= r_wtype;
         end
         if (w_start) r_issued[w_cand_bank] <= 1'b1;
         if (w_free_rd) begin
            r_full[r_out_bank]   <= 1'b0;
            r_issued[r_out_bank] <= 1'b0;
            r_oldest             <= ~r_out_bank;
         end else if (w_commit && r_full == 2'b00) begin
            r_oldest <= r_wbank;
         end
      end
   end

   always_ff @(posedge ul1Clock or negedge ul1ResetN) begin
      if (!ul1ResetN) begin
         r_status <= '0;
      end else begin
         r_status.overflow      <= w_set_ovf  | (r_status.overflow      & ~ul1ClearErrors);
         r_status.length        <= w_set_len  | (r_status.length        & ~ul1ClearErrors);
         r_status.type_mismatch <= w_set_type | (r_status.type_mismatch & ~ul1ClearErrors);
      end
   end

   image_transfer_bank_ram #(
      .MB_PIXELS (MB_PIXELS),
      .ADDR_W    (ADDR_W)
   ) u_bank_ram (
      .i_clk   (ul1Clock),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (ul24Rgb24Data),
      .i_re    (w_re),
      .i_raddr (w_raddr),
      .o_rdata (w_ram_q)
   );

   assign ul1OutValid    = r_out_vld;
   assign ul24OutData    = r_out_data;
   assign eOutType       = r_out_type;
   assign ul1OutLast     = r_out_last;
   assign ul1Overflow    = r_status.overflow;
   assign ul1LengthError = r_status.length;
   assign ul1TypeError   = r_status.type_mismatch;

endmodule

// File: tb/tb_image_transfer_receiver.sv
// Scoreboard bench for image_transfer_receiver: expected pixels are queued as
// beats are driven and compared on every output handshake.
module tb_image_transfer_receiver;
   import P_ImageProcessing::*;

   localparam int MBP = 64;

   logic            ul1Clock;
   logic            ul1ResetN;
   logic            ul1Active;
   teMacroBlockType eMacroBlockType;
   logic [23:0]     ul24Rgb24Data;
   logic            ul1MacroBlockEnd;
   logic            ul1OutValid;
   logic            ul1OutReady;
   logic [23:0]     ul24OutData;
   teMacroBlockType eOutType;
   logic            ul1OutLast;
   logic            ul1ClearErrors;
   logic            ul1Overflow;
   logic            ul1LengthError;
   logic            ul1TypeError;

   int          n_checks = 0;
   int          n_fails  = 0;
   int          cyc = 0;
   int          first_valid_cyc = -1;
   int          last_end_cyc = 0;
   int          e1;
   bit          seen_valid = 1'b0;
   logic [26:0] sb [$];
   logic [26:0] exp_pix;

   image_transfer_receiver #(.MB_PIXELS(MBP)) u_dut (
      .ul1Clock         (ul1Clock),
      .ul1ResetN        (ul1ResetN),
      .ul1Active        (ul1Active),
      .eMacroBlockType  (eMacroBlockType),
      .ul24Rgb24Data    (ul24Rgb24Data),
      .ul1MacroBlockEnd (ul1MacroBlockEnd),
      .ul1OutValid      (ul1OutValid),
      .ul1OutReady      (ul1OutReady),
      .ul24OutData      (ul24OutData),
      .eOutType         (eOutType),
      .ul1OutLast       (ul1OutLast),
      .ul1ClearErrors   (ul1ClearErrors),
      .ul1Overflow      (ul1Overflow),
      .ul1LengthError   (ul1LengthError),
      .ul1TypeError     (ul1TypeError)
   );

   initial begin
      ul1Clock = 1'b0;
      forever #5 ul1Clock = ~ul1Clock;
   end

   always @(posedge ul1Clock) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Handshakes happen at the posedge following a negedge with valid & ready.
   always @(negedge ul1Clock) begin
      if (ul1ResetN && ul1OutValid) begin
         if (!seen_valid) begin
            seen_valid      = 1'b1;
            first_valid_cyc = cyc;
         end
         if (ul1OutReady) begin
            if (sb.size() == 0) begin
               check_value("unexpected_pixel", {5'd0, ul1OutLast, eOutType, ul24OutData}, 32'h0);
            end else begin
               exp_pix = sb.pop_front();
               check_value("pixel", {5'd0, ul1OutLast, eOutType, ul24OutData}, {5'd0, exp_pix});
            end
         end
      end
   end

   task automatic tick();
      @(posedge ul1Clock);
      #1;
   endtask

   task automatic pulse_clear();
      ul1ClearErrors = 1'b1;
      tick();
      ul1ClearErrors = 1'b0;
   endtask

   task automatic check_flags(input string tag, input logic [2:0] exp);
      check_value(tag, {29'd0, ul1Overflow, ul1LengthError, ul1TypeError}, {29'd0, exp});
   endtask

   task automatic wait_drain(input int budget);
      int c = 0;
      while (sb.size() != 0 && c < budget) begin
         tick();
         c++;
      end
      check_value("drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic send_mb(input teMacroBlockType t, input int base, input int n, input bit gaps,
                          input bit expect_out, input int chg_at, input int clr_at);
      logic l;
      for (int i = 0; i < n; i++) begin
         ul1Active        = 1'b1;
         ul24Rgb24Data    = 24'(base + i);
         eMacroBlockType  = (chg_at >= 0 && i >= chg_at) ? ((t == MB_INTRA) ? MB_INTER : MB_INTRA) : t;
         ul1MacroBlockEnd = (i == n - 1);
         ul1ClearErrors   = (i == clr_at);
         if (i == n - 1) last_end_cyc = cyc + 1;
         l = (i == MBP - 1);
         if (expect_out) sb.push_back({l, t, 24'(base + i)});
         tick();
         ul1Active        = 1'b0;
         ul1MacroBlockEnd = 1'b0;
         ul1ClearErrors   = 1'b0;
         if (gaps) tick();
      end
   endtask

   initial begin
      int c;
      ul1ResetN        = 1'b0;
      ul1Active        = 1'b0;
      eMacroBlockType  = MB_INTRA;
      ul24Rgb24Data    = '0;
      ul1MacroBlockEnd = 1'b0;
      ul1OutReady      = 1'b1;
      ul1ClearErrors   = 1'b0;
      repeat (3) tick();
      check_value("rst_valid", 32'(ul1OutValid), 32'd0);
      check_value("rst_data", 32'(ul24OutData), 32'd0);
      check_flags("rst_flags", 3'b000);
      ul1ResetN = 1'b1;
      tick();

      // back-to-back macroblocks, index data
      send_mb(MB_INTRA, 0, MBP, 1'b0, 1'b1, -1, -1);
      e1 = last_end_cyc;
      send_mb(MB_INTER, MBP, MBP, 1'b0, 1'b1, -1, -1);
      wait_drain(400);
      check_value("first_valid_latency", 32'(first_valid_cyc - e1), 32'd2);
      check_flags("b2b_flags", 3'b000);

      // 1/0 toggling ul1Active
      send_mb(MB_INTRA, 0, MBP, 1'b1, 1'b1, -1, -1);
      wait_drain(400);
      check_flags("gaps_flags", 3'b000);

      // overflow with output stalled
      ul1OutReady = 1'b0;
      send_mb(MB_INTRA, 'h100, MBP, 1'b0, 1'b1, -1, -1);
      send_mb(MB_INTER, 'h200, MBP, 1'b0, 1'b1, -1, -1);
      send_mb(MB_SKIP,  'h300, MBP, 1'b0, 1'b0, -1, -1);
      repeat (4) tick();
      check_flags("ovf_flags", 3'b100);
      check_value("stall_valid", 32'(ul1OutValid), 32'd1);
      check_value("stall_data", 32'(ul24OutData), 32'h100);
      ul1OutReady = 1'b1;
      c = 0;
      while (sb.size() > MBP && c < 400) begin
         tick();
         c++;
      end
      check_value("bank_free_wait", 32'(sb.size() > MBP), 32'd0);
      repeat (2) tick();
      send_mb(MB_SKIP, 'h400, MBP, 1'b0, 1'b1, -1, -1);
      wait_drain(400);
      check_flags("ovf_sticky", 3'b100);
      pulse_clear();
      check_flags("ovf_cleared", 3'b000);

      // length errors: short and long macroblocks are not replayed
      send_mb(MB_INTRA, 'h500, 11, 1'b0, 1'b0, -1, -1);
      tick();
      check_flags("len_short", 3'b010);
      pulse_clear();
      check_flags("len_cleared", 3'b000);
      send_mb(MB_INTER, 'h580, 70, 1'b0, 1'b0, -1, -1);
      tick();
      check_flags("len_long", 3'b010);
      send_mb(MB_SKIP, 'h5C0, MBP, 1'b0, 1'b1, -1, -1);
      wait_drain(400);
      check_flags("len_after_good", 3'b010);
      pulse_clear();

      // type change at pixel 5; clear at pixel 6 loses to the set
      send_mb(MB_INTRA, 'h600, MBP, 1'b0, 1'b1, 5, 6);
      check_flags("type_err", 3'b001);
      wait_drain(400);
      pulse_clear();
      check_flags("type_cleared", 3'b000);

      // reset mid-fill
      for (int i = 0; i < 30; i++) begin
         ul1Active       = 1'b1;
         ul24Rgb24Data   = 24'('h680 + i);
         eMacroBlockType = (i >= 3) ? MB_SKIP : MB_INTER;
         tick();
      end
      ul1Active = 1'b0;
      check_flags("midfill_pre", 3'b001);
      ul1ResetN = 1'b0;
      #1;
      check_value("midfill_valid", 32'(ul1OutValid), 32'd0);
      check_value("midfill_data", 32'(ul24OutData), 32'd0);
      check_flags("midfill_flags", 3'b000);
      sb.delete();
      tick();
      ul1ResetN = 1'b1;
      tick();

      // reset mid-replay
      send_mb(MB_SKIP, 'h700, MBP, 1'b0, 1'b1, -1, -1);
      c = 0;
      while (!ul1OutValid && c < 20) begin
         tick();
         c++;
      end
      repeat (5) tick();
      check_value("replay_pre_valid", 32'(ul1OutValid), 32'd1);
      ul1ResetN = 1'b0;
      #1;
      check_value("replay_valid", 32'(ul1OutValid), 32'd0);
      check_value("replay_last", 32'(ul1OutLast), 32'd0);
      check_value("replay_data", 32'(ul24OutData), 32'd0);
      check_value("replay_type", 32'(eOutType), 32'd0);
      sb.delete();
      tick();
      ul1ResetN = 1'b1;
      tick();
      send_mb(MB_INTER, 'h800, MBP, 1'b0, 1'b1, -1, -1);
      wait_drain(400);
      check_flags("post_reset_flags", 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/image_transfer_receiver.md
Name: image_transfer_receiver

Overview:
Destination end of the tIImageTransfer protocol (dest modport signals, flattened). It captures one macroblock at a time of RGB24 pixels into a two-bank ping-pong buffer and checks protocol framing. It then replays each completed macroblock downstream over a valid/ready stream. The source has no backpressure, so overruns and framing faults are reported through sticky flags and never stall the source.

Parameters:
MB_PIXELS, 64, pixels per macroblock (power of 2, 4..256)
ADDR_W, $clog2(MB_PIXELS), buffer address / pixel counter width

Ports:
ul1Clock  in  1  common clock, same as tIImageTransfer.ul1Clock
ul1ResetN  in  1  asynchronous active-low reset
ul1Active  in  1  pixel beat valid this cycle
eMacroBlockType  in  teMacroBlockType  type of macroblock being transferred
ul24Rgb24Data  in  24  RGB24 pixel
ul1MacroBlockEnd  in  1  last pixel of macroblock (qualified by ul1Active)
ul1OutValid  out  1  output pixel valid
ul1OutReady  in  1  downstream accepts
ul24OutData  out  24  output pixel
eOutType  out  teMacroBlockType  type of macroblock being replayed
ul1OutLast  out  1  last pixel of replayed macroblock
ul1ClearErrors  in  1  synchronous clear of sticky flags
ul1Overflow  out  1  sticky: pixel dropped, no free bank
ul1LengthError  out  1  sticky: macroblock not exactly MB_PIXELS
ul1TypeError  out  1  sticky: type changed inside a macroblock

Behaviour:
- Reset: all outputs 0; both banks empty; write FSM in W_IDLE; read FSM in R_IDLE; counters 0.
- Beats: a beat is a cycle with ul1Active=1. Gaps (ul1Active=0) are legal mid-macroblock; state is held. ul1MacroBlockEnd is ignored when ul1Active=0.
- Write FSM states: W_IDLE, W_FILL, W_DROP.
  - W_IDLE, beat arrives, free bank available: write pixel at address 0, latch type, go to W_FILL (or commit immediately if End is set and MB_PIXELS=1; not legal since MB_PIXELS≥4, so this raises LengthError).
  - W_IDLE, beat arrives, no free bank: set Overflow, go to W_DROP.
  - W_FILL, each beat: write at count, count++. A type mismatch against the latched type sets TypeError; the latched type is kept.
  - W_FILL, End on beat with count==MB_PIXELS-1: commit bank (full flag and type set at that edge), go to W_IDLE.
  - W_FILL, End with count<MB_PIXELS-1: set LengthError, discard bank, go to W_IDLE.
  - W_FILL, beat with count==MB_PIXELS and no End: set LengthError, discard bank, go to W_DROP.
  - W_DROP: discard beats until a beat with End, then go to W_IDLE.
- Bank selection: the writer takes the lowest-index free bank. A bank freed by the reader becomes usable by the writer on the following cycle; a beat in the same cycle with no other free bank is an overflow.
- Read FSM states: R_IDLE, R_STREAM.
  - Replay order is commit order, tracked by a one-bit oldest pointer.
  - Latency: End beat sampled at edge N; bank full at N; RAM read issued in cycle N+1; ul1OutValid=1 after edge N+2.
  - Output registers hold while ul1OutValid & !ul1OutReady.
  - One-entry prefetch sustains 1 pixel/cycle while ul1OutReady=1.
  - ul1OutLast=1 on pixel MB_PIXELS-1. Its handshake frees the bank and returns to R_IDLE, or goes directly to the next full bank with no bubble.
- Sticky flags set at the faulting edge. ul1ClearErrors clears them; a set in the same cycle wins.
- Buffer: 2×MB_PIXELS×24, one write port and one read port, synchronous read.

Decomposition:
- Package P_ImageProcessing: existing teMacroBlockType; add localparam default MB_PIXELS and typedef tsRxStatus {overflow, length, type}.
- Sub-module image_transfer_bank_ram: 2-bank simple-dual-port RAM with registered read.

Test Plan:
- Two back-to-back 64-pixel MBs, data=index, types A then B, ul1OutReady=1 → 128 output pixels in order, OutLast at 63 and 127, eOutType A then B, ul1OutValid first high 2 cycles after first End.
- One MB with ul1Active toggling 1/0 each cycle → identical output to the gapless case, no flags.
- ul1OutReady=0, three MBs sent → first two replayed intact after ready rises; ul1Overflow=1; third MB fully dropped; writer accepts a fourth MB once a bank frees.
- End at pixel 10; then a 70-beat MB with End on beat 70 → LengthError=1; neither MB emitted; the next good MB replays correctly.
- Type changes at pixel 5 → TypeError=1, MB replayed with the first type; ul1ClearErrors pulse → flag 0.
- ul1ResetN asserted mid-fill and mid-replay → all outputs 0 asynchronously; after release, a fresh MB passes cleanly.
